// File: rtl/bus_arbiter_pkg.sv
// Shared state encoding, region/master indices and default memory map
// for the two-master on-chip bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam int REG_ROM = 0;
    localparam int REG_RAM = 1;
    localparam int REG_IO  = 2;

    localparam int M0 = 0;
    localparam int M1 = 1;

    localparam logic [31:0] DEF_ROM_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_ROM_SIZE = 32'h0000_1000;
    localparam logic [31:0] DEF_RAM_BASE = 32'h0000_1000;
    localparam logic [31:0] DEF_RAM_SIZE = 32'h0000_1000;
    localparam logic [31:0] DEF_IO_BASE  = 32'h1000_0000;
    localparam logic [31:0] DEF_IO_SIZE  = 32'h0000_0010;
    localparam int          DEF_TIMEOUT  = 16;

    // 33-bit compare so a region ending at 4 GiB never wraps to zero
    function automatic logic in_region(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] size
    );
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + {1'b0, size};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/bus_arbiter_addr_decoder.sv
// Combinational region decode: address + strobes -> one-hot region,
// region-relative offset and an illegal-access flag.
module bus_arbiter_addr_decoder
    import bus_arbiter_pkg::*;
#(
    parameter logic [31:0] ROM_BASE = DEF_ROM_BASE,
    parameter logic [31:0] ROM_SIZE = DEF_ROM_SIZE,
    parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
    parameter logic [31:0] RAM_SIZE = DEF_RAM_SIZE,
    parameter logic [31:0] IO_BASE  = DEF_IO_BASE,
    parameter logic [31:0] IO_SIZE  = DEF_IO_SIZE
) (
    input  logic [31:0] addr_i,
    input  logic [3:0]  wstrb_i,
    input  logic        instr_i,
    output logic [2:0]  region_o,
    output logic [31:0] offset_o,
    output logic        illegal_o
);

    logic write;

    always_comb begin
        write    = |wstrb_i;
        region_o = '0;
        offset_o = addr_i;
        if (in_region(addr_i, ROM_BASE, ROM_SIZE)) begin
            region_o[REG_ROM] = 1'b1;
            offset_o          = addr_i - ROM_BASE;
        end else if (in_region(addr_i, RAM_BASE, RAM_SIZE)) begin
            region_o[REG_RAM] = 1'b1;
            offset_o          = addr_i - RAM_BASE;
        end else if (in_region(addr_i, IO_BASE, IO_SIZE)) begin
            region_o[REG_IO] = 1'b1;
            offset_o         = addr_i - IO_BASE;
        end
        // a fetch is never a write; ROM is read-only
        illegal_o = (region_o == 3'b000)
                  || (region_o[REG_ROM] && write)
                  || (instr_i && write);
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for two native-protocol masters onto ROM/RAM/IO,
// with registered completion and timeout-based error termination.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter logic [31:0] ROM_BASE = DEF_ROM_BASE,
    parameter logic [31:0] ROM_SIZE = DEF_ROM_SIZE,
    parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
    parameter logic [31:0] RAM_SIZE = DEF_RAM_SIZE,
    parameter logic [31:0] IO_BASE  = DEF_IO_BASE,
    parameter logic [31:0] IO_SIZE  = DEF_IO_SIZE,
    parameter int          TIMEOUT  = DEF_TIMEOUT
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [1:0]  m_valid,
    input  logic [1:0]  m_instr,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    input  logic [7:0]  m_wstrb,
    output logic [1:0]  m_ready,
    output logic [31:0] m_rdata,
    output logic [2:0]  s_enable,
    output logic        s_write,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [95:0] s_rdata,
    input  logic [2:0]  s_ready,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam int CW = $clog2(TIMEOUT);

    state_e        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    m_ready_q, m_ready_d;
    logic [31:0]   m_rdata_q, m_rdata_d;
    logic [2:0]    s_enable_q, s_enable_d;
    logic          s_write_q, s_write_d;
    logic [31:0]   s_addr_q, s_addr_d;
    logic [31:0]   s_wdata_q, s_wdata_d;
    logic [3:0]    s_wstrb_q, s_wstrb_d;
    logic          err_q, err_d;
    logic [31:0]   err_addr_q, err_addr_d;

    logic          win;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;
    logic          req_instr;
    logic [2:0]    dec_region;
    logic [31:0]   dec_offset;
    logic          dec_illegal;
    logic          hit;
    logic          expire;
    logic [31:0]   rd_sel;

    // the master that did not win last time takes a tie
    always_comb begin
        win       = (m_valid == 2'b11) ? ~last_q : m_valid[M1];
        req_addr  = win ? m_addr[M1*32 +: 32]  : m_addr[M0*32 +: 32];
        req_wdata = win ? m_wdata[M1*32 +: 32] : m_wdata[M0*32 +: 32];
        req_wstrb = win ? m_wstrb[M1*4 +: 4]   : m_wstrb[M0*4 +: 4];
        req_instr = win ? m_instr[M1]          : m_instr[M0];
    end

    bus_arbiter_addr_decoder #(
        .ROM_BASE (ROM_BASE),
        .ROM_SIZE (ROM_SIZE),
        .RAM_BASE (RAM_BASE),
        .RAM_SIZE (RAM_SIZE),
        .IO_BASE  (IO_BASE),
        .IO_SIZE  (IO_SIZE)
    ) u_dec (
        .addr_i    (req_addr),
        .wstrb_i   (req_wstrb),
        .instr_i   (req_instr),
        .region_o  (dec_region),
        .offset_o  (dec_offset),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        hit    = |(s_ready & s_enable_q);
        expire = (cnt_q == CW'(TIMEOUT - 1)) || (pend_q && cnt_q == CW'(1));
        rd_sel = ({32{s_enable_q[REG_ROM]}} & s_rdata[REG_ROM*32 +: 32])
               | ({32{s_enable_q[REG_RAM]}} & s_rdata[REG_RAM*32 +: 32])
               | ({32{s_enable_q[REG_IO]}}  & s_rdata[REG_IO*32 +: 32]);
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        m_ready_d  = '0;
        m_rdata_d  = m_rdata_q;
        s_enable_d = s_enable_q;
        s_write_d  = s_write_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_wstrb_d  = s_wstrb_q;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (|m_valid) begin
                    grant_d    = win;
                    pend_d     = dec_illegal;
                    addr_d     = req_addr;
                    s_enable_d = dec_illegal ? 3'b000 : dec_region;
                    s_write_d  = |req_wstrb;
                    s_addr_d   = dec_offset;
                    s_wdata_d  = req_wdata;
                    s_wstrb_d  = req_wstrb;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                if (hit) begin
                    m_rdata_d          = rd_sel;
                    s_enable_d         = '0;
                    m_ready_d[grant_q] = 1'b1;
                    state_d            = ST_DONE;
                end else if (expire) begin
                    m_rdata_d          = '0;
                    s_enable_d         = '0;
                    err_d              = 1'b1;
                    err_addr_d         = addr_q;
                    m_ready_d[grant_q] = 1'b1;
                    state_d            = ST_DONE;
                end
            end
            ST_DONE: begin
                last_d  = grant_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'(M1);
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            m_ready_q  <= '0;
            m_rdata_q  <= '0;
            s_enable_q <= '0;
            s_write_q  <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wstrb_q  <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            m_ready_q  <= m_ready_d;
            m_rdata_q  <= m_rdata_d;
            s_enable_q <= s_enable_d;
            s_write_q  <= s_write_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_wstrb_q  <= s_wstrb_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign m_ready  = m_ready_q;
    assign m_rdata  = m_rdata_q;
    assign s_enable = s_enable_q;
    assign s_write  = s_write_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_wstrb  = s_wstrb_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a per-cycle expectation timeline built
// from the memory map and latency rules, checked on every falling edge.
module tb_bus_arbiter;

    localparam int TO = 16;
    localparam int N  = 1024;

    logic        clk_in   = 1'b0;
    logic        reset_in = 1'b1;
    logic [1:0]  m_valid  = '0;
    logic [1:0]  m_instr  = '0;
    logic [63:0] m_addr   = '0;
    logic [63:0] m_wdata  = '0;
    logic [7:0]  m_wstrb  = '0;
    logic [95:0] s_rdata  = '0;
    logic [2:0]  s_ready  = '0;
    logic [1:0]  m_ready;
    logic [31:0] m_rdata;
    logic [2:0]  s_enable;
    logic        s_write;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        err;
    logic [31:0] err_addr;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    bit [1:0]  exp_rdy [N];
    bit        exp_err [N];
    bit [2:0]  exp_en  [N];
    bit [31:0] exp_sa  [N];
    bit        exp_sw  [N];
    bit [31:0] exp_wd  [N];
    bit [3:0]  exp_ws  [N];
    bit [31:0] exp_rd  [N];
    bit        exp_eal [N];
    bit [31:0] exp_ea  [N];

    bit [31:0]   model_ea   = '0;
    int          model_last = 1;
    int          rdy_cnt [2];
    int          err_cnt       = 0;
    int          last_rdy_cyc  = 0;
    logic [1:0]  last_rdy_mask = '0;
    logic [31:0] last_rdy_data = '0;

    bus_arbiter dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .m_valid  (m_valid),
        .m_instr  (m_instr),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_ready  (m_ready),
        .m_rdata  (m_rdata),
        .s_enable (s_enable),
        .s_write  (s_write),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_rdata  (s_rdata),
        .s_ready  (s_ready),
        .err      (err),
        .err_addr (err_addr)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // memory map straight from the region table
    function automatic void model_decode(input logic [31:0] a,
                                         input logic [3:0] ws,
                                         output int r,
                                         output logic [31:0] off,
                                         output bit ill);
        r   = -1;
        off = '0;
        if (a < 32'h1000) begin
            r = 0; off = a;
        end else if (a >= 32'h1000 && a < 32'h2000) begin
            r = 1; off = a - 32'h1000;
        end else if (a >= 32'h1000_0000 && a < 32'h1000_0010) begin
            r = 2; off = a - 32'h1000_0000;
        end
        ill = (r < 0) || (r == 0 && ws != 0);
    endfunction

    task automatic setm(input int m, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input logic ins);
        m_addr[m*32 +: 32]  = a;
        m_wdata[m*32 +: 32] = wd;
        m_wstrb[m*4 +: 4]   = ws;
        m_instr[m]          = ins;
    endtask

    // called in the IDLE cycle where master m is the expected winner
    task automatic serve(input int m, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input int d, input logic [31:0] data);
        int c, r, done;
        logic [31:0] off;
        bit ill, bad;
        c = cyc;
        model_decode(a, ws, r, off, ill);
        bad = ill || (d < 0);
        if (ill)        done = c + 3;
        else if (d < 0) done = c + 1 + TO;
        else            done = c + d + 2;
        if (!ill) begin
            for (int n = c + 1; n < done; n++) begin
                exp_en[n] = 3'(1 << r);
                exp_sa[n] = off;
                exp_sw[n] = (ws != 0);
                exp_wd[n] = wd;
                exp_ws[n] = ws;
            end
        end
        exp_rdy[done][m] = 1'b1;
        exp_err[done]    = bad;
        exp_rd[done]     = bad ? 32'h0 : data;
        if (bad) begin
            exp_eal[done] = 1'b1;
            exp_ea[done]  = a;
        end
        step();
        m_valid[m] = 1'b0;
        if (!ill && d >= 0) begin
            repeat (d) step();
            s_rdata[r*32 +: 32] = data;
            s_ready[r] = 1'b1;
            step();
            s_ready[r] = 1'b0;
        end
        while (cyc <= done) step();
        model_last = m;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        exp_eal[cyc+1] = 1'b1;
        exp_ea[cyc+1]  = '0;
        step();
        reset_in   = 1'b0;
        model_last = 1;
    endtask

    always @(negedge clk_in) begin
        if (chk_en && cyc < N) begin
            if (exp_eal[cyc]) model_ea = exp_ea[cyc];
            chk("m_ready", 32'(m_ready), 32'(exp_rdy[cyc]));
            chk("err", 32'(err), 32'(exp_err[cyc]));
            chk("err_addr", err_addr, model_ea);
            chk("s_enable", 32'(s_enable), 32'(exp_en[cyc]));
            if (exp_en[cyc] != 0) begin
                chk("s_addr", s_addr, exp_sa[cyc]);
                chk("s_write", 32'(s_write), 32'(exp_sw[cyc]));
                chk("s_wdata", s_wdata, exp_wd[cyc]);
                chk("s_wstrb", 32'(s_wstrb), 32'(exp_ws[cyc]));
            end
            if (exp_rdy[cyc] != 0) chk("m_rdata", m_rdata, exp_rd[cyc]);
            if (m_ready[0] === 1'b1) rdy_cnt[0]++;
            if (m_ready[1] === 1'b1) rdy_cnt[1]++;
            if (m_ready != 0) begin
                last_rdy_cyc  = cyc;
                last_rdy_mask = m_ready;
                last_rdy_data = m_rdata;
            end
            if (err === 1'b1) err_cnt++;
        end
    end

    initial begin
        int c0, r0, r1, e0, g, w;
        logic [31:0] a0, a1, d0, d1;

        step();
        reset_in = 1'b0;
        step();
        chk("rst_m_ready", 32'(m_ready), 32'h0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_s_enable", 32'(s_enable), 32'h0);
        chk("rst_s_write", 32'(s_write), 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_s_wdata", s_wdata, 32'h0);
        chk("rst_s_wstrb", 32'(s_wstrb), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk_en = 1'b1;

        c0 = cyc;
        setm(0, 32'h0000_0004, '0, 4'h0, 1'b1);
        m_valid = 2'b01;
        serve(0, 32'h0000_0004, '0, 4'h0, 1, 32'hDEAD_BEEF);
        chk("rom_latency", 32'(last_rdy_cyc - c0), 32'd3);
        chk("rom_rdata", last_rdy_data, 32'hDEAD_BEEF);

        e0 = err_cnt;
        setm(0, 32'h0000_1010, 32'h1234_5678, 4'hF, 1'b0);
        m_valid = 2'b01;
        serve(0, 32'h0000_1010, 32'h1234_5678, 4'hF, 0, 32'hCAFE_0001);
        chk("ram_wr_no_err", 32'(err_cnt - e0), 32'd0);

        do_reset();
        r0 = rdy_cnt[0];
        r1 = rdy_cnt[1];
        g  = 0;
        for (int rep = 0; rep < 4; rep++) begin
            a0 = 32'h1000 + 32'(rep * 16);
            a1 = 32'h1800 + 32'(rep * 4);
            d0 = 32'hA000_0000 + 32'(rep);
            d1 = 32'hB000_0000 + 32'(rep);
            setm(0, a0, '0, 4'h0, 1'b0);
            setm(1, a1, 32'h5500_0000 + 32'(rep), 4'h3, 1'b0);
            m_valid = 2'b11;
            w = (model_last == 0) ? 1 : 0;
            if (w == 0) serve(0, a0, '0, 4'h0, rep % 3, d0);
            else serve(1, a1, 32'h5500_0000 + 32'(rep), 4'h3, rep % 3, d1);
            chk("grant_order", 32'(last_rdy_mask), (g % 2 == 0) ? 32'h1 : 32'h2);
            g++;
            if (w == 0) serve(1, a1, 32'h5500_0000 + 32'(rep), 4'h3, 1, d1);
            else serve(0, a0, '0, 4'h0, 1, d0);
            chk("grant_order", 32'(last_rdy_mask), (g % 2 == 0) ? 32'h1 : 32'h2);
            g++;
        end
        chk("m0_ready_count", 32'(rdy_cnt[0] - r0), 32'd4);
        chk("m1_ready_count", 32'(rdy_cnt[1] - r1), 32'd4);

        setm(1, 32'h2000_0000, '0, 4'h0, 1'b0);
        m_valid = 2'b10;
        serve(1, 32'h2000_0000, '0, 4'h0, 0, 32'h0);
        chk("unmapped_err_addr", err_addr, 32'h2000_0000);
        chk("unmapped_rdata", last_rdy_data, 32'h0);

        s_ready = 3'b001;
        setm(0, 32'h0000_0000, 32'h0000_00AA, 4'hF, 1'b0);
        m_valid = 2'b01;
        serve(0, 32'h0000_0000, 32'h0000_00AA, 4'hF, 0, 32'h0);
        s_ready = 3'b000;
        chk("rom_wr_err_addr", err_addr, 32'h0);
        chk("rom_wr_mask", 32'(last_rdy_mask), 32'h1);

        e0 = err_cnt;
        c0 = cyc;
        s_ready = 3'b011;
        setm(0, 32'h1000_0004, '0, 4'h0, 1'b0);
        m_valid = 2'b01;
        serve(0, 32'h1000_0004, '0, 4'h0, -1, 32'h0);
        s_ready = 3'b000;
        chk("timeout_latency", 32'(last_rdy_cyc - c0), 32'd17);
        chk("timeout_err_count", 32'(err_cnt - e0), 32'd1);

        setm(0, 32'h0000_1ffc, '0, 4'h0, 1'b0);
        m_valid = 2'b01;
        serve(0, 32'h0000_1ffc, '0, 4'h0, 2, 32'h0BAD_F00D);
        chk("after_timeout_rdata", last_rdy_data, 32'h0BAD_F00D);

        setm(0, 32'h0000_0100, '0, 4'h0, 1'b0);
        setm(1, 32'h1000_000c, 32'h0000_0077, 4'h1, 1'b0);
        m_valid = 2'b11;
        serve(1, 32'h1000_000c, 32'h0000_0077, 4'h1, 0, 32'h0000_0001);
        chk("tie_after_m0", 32'(last_rdy_mask), 32'h2);
        serve(0, 32'h0000_0100, '0, 4'h0, 0, 32'h0000_0100);
        chk("tie_second", 32'(last_rdy_mask), 32'h1);

        r0 = rdy_cnt[0];
        c0 = cyc;
        setm(0, 32'h0000_1008, '0, 4'h0, 1'b0);
        m_valid = 2'b01;
        exp_en[c0+1] = 3'b010;
        exp_sa[c0+1] = 32'h8;
        exp_sw[c0+1] = 1'b0;
        exp_wd[c0+1] = '0;
        exp_ws[c0+1] = '0;
        step();
        m_valid = 2'b00;
        s_rdata[63:32] = 32'hBAD0_BAD0;
        s_ready = 3'b010;
        do_reset();
        s_ready = 3'b000;
        step();
        step();
        chk("reset_no_ready", 32'(rdy_cnt[0] - r0), 32'd0);
        setm(0, 32'h0000_0008, '0, 4'h0, 1'b0);
        m_valid = 2'b01;
        serve(0, 32'h0000_0008, '0, 4'h0, 0, 32'h1357_9BDF);
        chk("post_reset_rdata", last_rdy_data, 32'h1357_9BDF);
        chk("post_reset_count", 32'(rdy_cnt[0] - r0), 32'd1);

        step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
